// File: rtl/da_dct_pkg.sv
// da_dct_pkg: shared Q2.14 DCT coefficients, width defaults and FSM states.
package da_dct_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_OUT_W = 18;
    localparam int FRAC_W    = 14;
    localparam int LUT_W     = 16;

    typedef logic signed [LUT_W-1:0] coef_t;

    // C[n][k] of the orthonormal 4-point IDCT, Q2.14
    localparam coef_t C_Q14 [4][4] = '{
        '{16'sd8192,  16'sd10703,  16'sd8192,  16'sd4433},
        '{16'sd8192,  16'sd4433,  -16'sd8192, -16'sd10703},
        '{16'sd8192, -16'sd4433,  -16'sd8192,  16'sd10703},
        '{16'sd8192, -16'sd10703,  16'sd8192, -16'sd4433}
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

endpackage

// File: rtl/da_idct4_if.sv
// da_idct4_if: input/output handshake and sample buses of the 4-point IDCT.
interface da_idct4_if
    import da_dct_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  z0, z1, z2, z3;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] x0, x1, x2, x3;

    modport master (
        output in_valid, z0, z1, z2, z3, out_ready,
        input  in_ready, out_valid, x0, x1, x2, x3
    );

    modport slave (
        input  in_valid, z0, z1, z2, z3, out_ready,
        output in_ready, out_valid, x0, x1, x2, x3
    );
endinterface

// File: rtl/da_idct4_lut.sv
// da_idct4_lut: one IDCT row's distributed-arithmetic LUT, sum of C[ROW][k] over set address bits.
module da_idct4_lut
    import da_dct_pkg::*;
#(
    parameter int ROW = 0
) (
    input  logic [3:0] addr_i,
    input  logic       cs_i,
    output coef_t      data_o
);
    // addr_i[3] selects z0's coefficient, addr_i[0] selects z3's
    always_comb begin
        data_o = '0;
        for (int k = 0; k < 4; k++)
            data_o = data_o + ((cs_i && addr_i[3-k]) ? C_Q14[ROW][k] : coef_t'(0));
    end
endmodule

// File: rtl/da_idct4.sv
// da_idct4: bit-serial distributed-arithmetic 4-point IDCT, one coefficient bit per cycle.
module da_idct4
    import da_dct_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic     clk,
    input  logic     rst,
    da_idct4_if.slave io
);
    localparam int CNT_W = $clog2(IN_W);

    state_e                  state_q, state_d;
    logic [IN_W-1:0]         zs_q [4], zs_d [4];
    logic signed [ACC_W-1:0] acc_q [4], acc_d [4];
    logic signed [OUT_W-1:0] x_q [4], x_d [4];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              addr;
    logic                    cs;
    logic                    last;
    coef_t                   lut [4];

    assign addr = {zs_q[0][0], zs_q[1][0], zs_q[2][0], zs_q[3][0]};
    assign cs   = state_q == BUSY;
    assign last = cnt_q == CNT_W'(IN_W - 1);

    for (genvar r = 0; r < 4; r++) begin : g_lut
        da_idct4_lut #(.ROW(r)) u_lut (
            .addr_i(addr),
            .cs_i  (cs),
            .data_o(lut[r])
        );
    end

    always_comb begin
        state_d = state_q;
        zs_d    = zs_q;
        acc_d   = acc_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                state_d = BUSY;
                zs_d    = '{io.z0, io.z1, io.z2, io.z3};
                acc_d   = '{default: '0};
                cnt_d   = '0;
            end
            BUSY: begin
                // the top bit carries negative weight in two's complement
                for (int r = 0; r < 4; r++) begin
                    acc_d[r] = last ? acc_q[r] - (ACC_W'(lut[r]) <<< cnt_q)
                                    : acc_q[r] + (ACC_W'(lut[r]) <<< cnt_q);
                    zs_d[r]  = zs_q[r] >> 1;
                    if (last)
                        x_d[r] = OUT_W'(acc_d[r] >>> FRAC_W);
                end
                cnt_d = cnt_q + 1'b1;
                if (last)
                    state_d = DONE;
            end
            DONE: if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            zs_q    <= '{default: '0};
            acc_q   <= '{default: '0};
            x_q     <= '{default: '0};
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            zs_q    <= zs_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.in_ready  = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.x0        = x_q[0];
    assign io.x1        = x_q[1];
    assign io.x2        = x_q[2];
    assign io.x3        = x_q[3];
endmodule
